// File: rtl/float_divider.sv
// IEEE-754 binary32 divider z = a / b with stb/ack handshakes and restoring long division.
// Define FLOAT_DIVIDER_FTZ_EN to flush subnormal operands and results to signed zero.
module float_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [3:0] {
        get_a, get_b, unpack, special_cases, normalise_a, normalise_b,
        divide_0, divide_1, divide_2, divide_3, normalise_1, normalise_2,
        round, pack, put_z
    } state_t;

    localparam logic signed [9:0] E_SPECIAL = 10'sd128;
    localparam logic signed [9:0] E_ZERO    = -10'sd127;
    localparam logic signed [9:0] E_MIN     = -10'sd126;
    localparam logic signed [9:0] E_MAX     = 10'sd127;
    localparam logic [31:0]       QNAN      = 32'hFFC00000;

    state_t            state_reg;
    logic [31:0]       a_reg, b_reg;
    logic [23:0]       a_m_reg, b_m_reg, z_m_reg;
    logic signed [9:0] a_e_reg, b_e_reg, z_e_reg;
    logic              a_s_reg, b_s_reg, z_s_reg;
    logic              guard_reg, round_bit_reg, sticky_reg;
    logic [50:0]       quotient_reg, divisor_reg, dividend_reg, remainder_reg;
    logic [5:0]        count_reg;

    // Operand classification: index 0 is a, index 1 is b.
    logic signed [9:0] op_e [2];
    logic [23:0]       op_m [2];
    logic [1:0]        op_nan, op_inf, op_zero, op_sub;
    logic              sign_xor;

    assign op_e[0]  = a_e_reg;
    assign op_e[1]  = b_e_reg;
    assign op_m[0]  = a_m_reg;
    assign op_m[1]  = b_m_reg;
    assign sign_xor = a_s_reg ^ b_s_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_class
            assign op_nan[gi] = (op_e[gi] == E_SPECIAL) && (op_m[gi] != 24'd0);
            assign op_inf[gi] = (op_e[gi] == E_SPECIAL) && (op_m[gi] == 24'd0);
            assign op_sub[gi] = (op_e[gi] == E_ZERO);
`ifdef FLOAT_DIVIDER_FTZ_EN
            assign op_zero[gi] = op_sub[gi];
`else
            assign op_zero[gi] = op_sub[gi] && (op_m[gi] == 24'd0);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= get_a;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            case (state_reg)
                get_a: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a_reg       <= input_a;
                        input_a_ack <= 1'b0;
                        state_reg   <= get_b;
                    end
                end
                get_b: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b_reg       <= input_b;
                        input_b_ack <= 1'b0;
                        state_reg   <= unpack;
                    end
                end
                unpack: begin
                    a_m_reg   <= {1'b0, a_reg[22:0]};
                    b_m_reg   <= {1'b0, b_reg[22:0]};
                    a_e_reg   <= $signed({2'b00, a_reg[30:23]}) - 10'sd127;
                    b_e_reg   <= $signed({2'b00, b_reg[30:23]}) - 10'sd127;
                    a_s_reg   <= a_reg[31];
                    b_s_reg   <= b_reg[31];
                    state_reg <= special_cases;
                end
                special_cases: begin
                    state_reg <= put_z;
                    if (op_nan[0] || op_nan[1]) begin
                        output_z <= QNAN;
                    end else if (op_inf[0]) begin
                        output_z <= op_inf[1] ? QNAN : {sign_xor, 8'hFF, 23'd0};
                    end else if (op_inf[1]) begin
                        output_z <= {sign_xor, 31'd0};
                    end else if (op_zero[1]) begin
                        output_z <= op_zero[0] ? QNAN : {sign_xor, 8'hFF, 23'd0};
                    end else if (op_zero[0]) begin
                        output_z <= {sign_xor, 31'd0};
                    end else begin
                        // Subnormals keep a zero hidden bit and sit at the minimum exponent.
                        if (op_sub[0]) a_e_reg <= E_MIN;
                        else           a_m_reg[23] <= 1'b1;
                        if (op_sub[1]) b_e_reg <= E_MIN;
                        else           b_m_reg[23] <= 1'b1;
                        state_reg <= normalise_a;
                    end
                end
                normalise_a: begin
                    if (a_m_reg[23]) begin
                        state_reg <= normalise_b;
                    end else begin
                        a_m_reg <= a_m_reg << 1;
                        a_e_reg <= a_e_reg - 10'sd1;
                    end
                end
                normalise_b: begin
                    if (b_m_reg[23]) begin
                        state_reg <= divide_0;
                    end else begin
                        b_m_reg <= b_m_reg << 1;
                        b_e_reg <= b_e_reg - 10'sd1;
                    end
                end
                divide_0: begin
                    z_s_reg       <= sign_xor;
                    z_e_reg       <= a_e_reg - b_e_reg;
                    quotient_reg  <= 51'd0;
                    remainder_reg <= 51'd0;
                    count_reg     <= 6'd0;
                    dividend_reg  <= {a_m_reg, 27'd0};
                    divisor_reg   <= {27'd0, b_m_reg};
                    state_reg     <= divide_1;
                end
                divide_1: begin
                    quotient_reg  <= quotient_reg << 1;
                    remainder_reg <= {remainder_reg[49:0], dividend_reg[50]};
                    dividend_reg  <= dividend_reg << 1;
                    state_reg     <= divide_2;
                end
                divide_2: begin
                    if (remainder_reg >= divisor_reg) begin
                        quotient_reg[0] <= 1'b1;
                        remainder_reg   <= remainder_reg - divisor_reg;
                    end
                    if (count_reg == 6'd49) begin
                        state_reg <= divide_3;
                    end else begin
                        count_reg <= count_reg + 6'd1;
                        state_reg <= divide_1;
                    end
                end
                divide_3: begin
                    z_m_reg       <= quotient_reg[26:3];
                    guard_reg     <= quotient_reg[2];
                    round_bit_reg <= quotient_reg[1];
                    sticky_reg    <= quotient_reg[0] | (remainder_reg != 51'd0);
                    state_reg     <= normalise_1;
                end
                normalise_1: begin
                    if (!z_m_reg[23]) begin
                        z_m_reg       <= {z_m_reg[22:0], guard_reg};
                        guard_reg     <= round_bit_reg;
                        round_bit_reg <= 1'b0;
                        z_e_reg       <= z_e_reg - 10'sd1;
                    end else begin
                        state_reg <= normalise_2;
                    end
                end
                normalise_2: begin
                    // Denormalise into the subnormal range, folding lost bits into sticky.
                    if (z_e_reg < E_MIN) begin
                        z_e_reg       <= z_e_reg + 10'sd1;
                        z_m_reg       <= z_m_reg >> 1;
                        guard_reg     <= z_m_reg[0];
                        round_bit_reg <= guard_reg;
                        sticky_reg    <= sticky_reg | round_bit_reg;
                    end else begin
                        state_reg <= round;
                    end
                end
                round: begin
                    if (guard_reg && (round_bit_reg || sticky_reg || z_m_reg[0])) begin
                        z_m_reg <= z_m_reg + 24'd1;
                        if (z_m_reg == 24'hFFFFFF) z_e_reg <= z_e_reg + 10'sd1;
                    end
                    state_reg <= pack;
                end
                pack: begin
                    output_z[22:0]  <= z_m_reg[22:0];
                    output_z[30:23] <= z_e_reg[7:0] + 8'd127;
                    output_z[31]    <= z_s_reg;
                    if ((z_e_reg == E_MIN) && !z_m_reg[23]) begin
`ifdef FLOAT_DIVIDER_FTZ_EN
                        output_z[30:0] <= 31'd0;
`else
                        output_z[30:23] <= 8'd0;
`endif
                    end
                    if (z_e_reg > E_MAX) begin
                        output_z[22:0]  <= 23'd0;
                        output_z[30:23] <= 8'hFF;
                    end
                    state_reg <= put_z;
                end
                put_z: begin
                    output_z_stb <= 1'b1;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state_reg    <= get_a;
                    end
                end
                default: state_reg <= get_a;
            endcase
        end
    end
endmodule

// File: tb/tb_float_divider.sv
// Scoreboard bench for float_divider: directed vectors, handshake/reset checks, random operands
// against an exact integer-arithmetic IEEE division model.
module tb_float_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a, input_b;
    logic        input_a_stb, input_b_stb;
    logic        input_a_ack, input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } txn_t;
    txn_t exp_q[$];

    float_divider dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // Exact reference: scale the significand ratio up, divide with integers, round to nearest even.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic         sz, up;
        logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [127:0] num, den, q, r, kept, rest, half;
        int           xa, xb, base, p, e, lsb, drop, bexp;
        sz    = a[31] ^ b[31];
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
`ifdef FLOAT_DIVIDER_FTZ_EN
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
`else
        a_zero = (a[30:23] == 8'h00) && (a[22:0] == 23'd0);
        b_zero = (b[30:23] == 8'h00) && (b[22:0] == 23'd0);
`endif
        if (a_nan || b_nan) return 32'hFFC00000;
        if (a_inf) return b_inf ? 32'hFFC00000 : {sz, 8'hFF, 23'd0};
        if (b_inf) return {sz, 31'd0};
        if (b_zero) return a_zero ? 32'hFFC00000 : {sz, 8'hFF, 23'd0};
        if (a_zero) return {sz, 31'd0};
        num  = {104'd0, (a[30:23] != 8'h00), a[22:0]} << 62;
        den  = {104'd0, (b[30:23] != 8'h00), b[22:0]};
        xa   = (a[30:23] == 8'h00) ? -126 : int'(a[30:23]) - 127;
        xb   = (b[30:23] == 8'h00) ? -126 : int'(b[30:23]) - 127;
        q    = num / den;
        r    = num % den;
        base = xa - xb - 62;
        p    = 0;
        for (int i = 0; i < 128; i++) if (q[i]) p = i;
        e    = p + base;
        lsb  = (e - 23 > -149) ? e - 23 : -149;
        drop = lsb - base;
        if (drop > 120) return {sz, 31'd0};
        kept = q >> drop;
        rest = q - (kept << drop);
        half = 128'd1 << (drop - 1);
        up   = (rest > half) || ((rest == half) && ((r != 128'd0) || kept[0]));
        if (up) kept = kept + 128'd1;
        if (kept[24]) begin
            kept = kept >> 1;
            lsb  = lsb + 1;
        end
        if (!kept[23]) begin
`ifdef FLOAT_DIVIDER_FTZ_EN
            return {sz, 31'd0};
`else
            return {sz, 8'd0, kept[22:0]};
`endif
        end
        bexp = lsb + 150;
        if (bexp >= 255) return {sz, 8'hFF, 23'd0};
        return {sz, bexp[7:0], kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            1:       v[30:23] = 8'h00;
            2, 3:    v[30:23] = 8'($urandom_range(1, 40));
            4:       v[30:23] = 8'($urandom_range(215, 254));
            6:       v[30:23] = 8'($urandom_range(107, 147));
            7: begin
                case ($urandom_range(0, 3))
                    0:       v[30:0] = 31'd0;
                    1:       v[30:0] = {8'hFF, 23'd0};
                    2:       v[30:0] = {8'hFF, 1'b1, v[21:0]};
                    default: v[30:0] = 31'd1;
                endcase
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL %s timed out", name);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int bdly,
                        input bit has_exp, input logic [31:0] z);
        bit done;
        if (has_exp) exp_q.push_back('{a: a, b: b, z: z});
        input_a     = a;
        input_a_stb = 1'b1;
        done        = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (input_a_ack) done = 1'b1;
        end
        if (!done) timeout("input_a_handshake");
        @(posedge clk);
        #1 input_a_stb = 1'b0;
        repeat (bdly) @(posedge clk);
        #1;
        input_b     = b;
        input_b_stb = 1'b1;
        done        = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (input_b_ack) done = 1'b1;
        end
        if (!done) timeout("input_b_handshake");
        @(posedge clk);
        #1 input_b_stb = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) timeout("result_drain");
    endtask

    // Monitor: a result is consumed on any edge where stb and ack are both high.
    always @(negedge clk) begin
        txn_t t;
        if (!rst && output_z_stb && output_z_ack) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_result got=%h expected=none", output_z);
            end else begin
                t     = exp_q.pop_front();
                n_txn = n_txn + 1;
                if (output_z !== t.z) begin
                    n_fail = n_fail + 1;
                    $display("FAIL result txn=%0d a=%h b=%h got=%h expected=%h",
                             n_txn, t.a, t.b, output_z, t.z);
                end else begin
                    $display("txn %0d a=%h b=%h z=%h ok", n_txn, t.a, t.b, output_z);
                end
            end
        end
    end

    logic [31:0] dir_a [12] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h40000000,
                                32'h3F800000, 32'h00000000, 32'h7F800000, 32'hFF800000,
                                32'h3F800000, 32'h7FC00000, 32'h00800000, 32'h7F7FFFFF};
    logic [31:0] dir_b [12] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h40400000,
                                32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000,
                                32'h7F800000, 32'h3F800000, 32'h40000000, 32'h3F000000};
`ifdef FLOAT_DIVIDER_FTZ_EN
    localparam logic [31:0] TINY_Z = 32'h00000000;
`else
    localparam logic [31:0] TINY_Z = 32'h00400000;
`endif
    logic [31:0] dir_z [12] = '{32'h40400000, 32'hC0400000, 32'h3EAAAAAB, 32'h3F2AAAAB,
                                32'h7F800000, 32'hFFC00000, 32'hFFC00000, 32'hFF800000,
                                32'h00000000, 32'hFFC00000, TINY_Z,       32'h7F800000};

    initial begin
        logic [31:0] held, ra, rb;
        bit          seen;
        rst          = 1'b1;
        input_a      = 32'd0;
        input_b      = 32'd0;
        input_a_stb  = 1'b0;
        input_b_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_input_a_ack", {31'd0, input_a_ack}, 32'd0);
        check("reset_input_b_ack", {31'd0, input_b_ack}, 32'd0);
        check("reset_output_z_stb", {31'd0, output_z_stb}, 32'd0);
        rst          = 1'b0;
        output_z_ack = 1'b1;

        for (int i = 0; i < 12; i++) send(dir_a[i], dir_b[i], 0, 1'b1, dir_z[i]);
        wait_idle();

        // Result held while the consumer stalls.
        output_z_ack = 1'b0;
        send(32'h40C00000, 32'h40000000, 0, 1'b1, 32'h40400000);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (output_z_stb) seen = 1'b1;
        end
        if (!seen) timeout("output_z_stb_rise");
        held = output_z;
        repeat (10) begin
            @(negedge clk);
            check("hold_output_z_stb", {31'd0, output_z_stb}, 32'd1);
            check("hold_output_z", output_z, held);
        end
        @(posedge clk);
        #1 output_z_ack = 1'b1;
        @(posedge clk);
        #1 check("ack_drops_stb", {31'd0, output_z_stb}, 32'd0);
        @(posedge clk);
        #1 check("ack_rearms_input_a", {31'd0, input_a_ack}, 32'd1);

        send(32'h40C00000, 32'h40000000, 7, 1'b1, 32'h40400000);
        wait_idle();

        // Abort a division part-way through the divide loop.
        send(32'h40C00000, 32'h40000000, 0, 1'b0, 32'd0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_input_a_ack", {31'd0, input_a_ack}, 32'd0);
        check("midrst_input_b_ack", {31'd0, input_b_ack}, 32'd0);
        check("midrst_output_z_stb", {31'd0, output_z_stb}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("midrst_back_to_get_a", {31'd0, input_a_ack}, 32'd1);
        send(32'h40C00000, 32'h40000000, 0, 1'b1, 32'h40400000);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            send(ra, rb, $urandom_range(0, 2), 1'b1, ref_div(ra, rb));
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/float_divider.md
Name: float_divider

Overview:
- IEEE-754 binary32 divider computing z = a / b.
- Sits alongside the single-precision multiplier in the FPU datapath and uses the same three-channel stb/ack operand/result interface, so either unit can be driven by the same sequencer.
- Iterative restoring long division, one quotient bit per cycle, round-to-nearest-even, full subnormal support.

Parameters:
- none; the format is fixed binary32.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- input_a  input  32  dividend
- input_a_stb  input  1  dividend valid
- input_a_ack  output  1  divider ready for dividend
- input_b  input  32  divisor
- input_b_stb  input  1  divisor valid
- input_b_ack  output  1  divider ready for divisor
- output_z  output  32  quotient
- output_z_stb  output  1  quotient valid
- output_z_ack  input  1  consumer accepts quotient

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: state=get_a; input_a_ack=0, input_b_ack=0, output_z_stb=0. output_z is not reset.
- Reset priority: rst overrides any state, including mid-division. No partial result is ever emitted after reset.
- Operand handshake (identical for a and b):
  - In get_x, ack goes to 1 on the first cycle.
  - A transfer occurs on an edge where ack=1 and stb=1. The operand is latched, ack drops to 0 on that edge, and state advances.
  - Minimum 2 cycles per operand.
- Result handshake (put_z):
  - output_z_stb=1 with output_z=z.
  - Both are held stable until an edge with stb=1 and output_z_ack=1.
  - On that edge stb drops and state returns to get_a.
  - An ack while stb=0 is ignored.
- States in order: get_a, get_b, unpack, special_cases, normalise_a, normalise_b, divide_0, divide_1, divide_2, divide_3, normalise_1, normalise_2, round, pack, put_z.
- unpack:
  - m = frac[22:0].
  - e = exp - 127, 10-bit signed.
  - s = sign.
- special_cases, in priority order, each going straight to put_z:
  1. Either operand NaN → 0xFFC00000.
  2. a inf: b inf → 0xFFC00000; otherwise inf with sign a_s^b_s.
  3. b inf → zero with sign a_s^b_s.
  4. b zero: a zero → 0xFFC00000; otherwise inf with sign a_s^b_s.
  5. a zero → zero with sign a_s^b_s.
  6. Otherwise:
     - Subnormal operand: e = -126, hidden bit stays 0.
     - Normal operand: m[23] = 1.
     - Go to normalise_a.
- normalise_a / normalise_b: shift m left 1 and decrement e per cycle until m[23]=1. At most 23 cycles each.
- divide_0:
  - z_s = a_s^b_s.
  - z_e = a_e - b_e.
  - dividend = a_m << 27 (51 bits).
  - divisor = b_m.
  - quotient = 0, remainder = 0, count = 0.
- divide_1: quotient <<= 1; remainder = (remainder << 1) | dividend[50]; dividend <<= 1.
- divide_2:
  - If remainder >= divisor: quotient[0] = 1 and remainder -= divisor.
  - If count == 49, go to divide_3. Otherwise count++ and return to divide_1.
  - Total: exactly 50 iterations, 100 cycles.
- divide_3:
  - z_m = quotient[26:3].
  - guard = quotient[2], round_bit = quotient[1].
  - sticky = quotient[0] | (remainder != 0).
- normalise_1: while z_m[23]==0, shift left 1, shifting guard into bit 0 (guard←round_bit, round_bit←0), and decrement z_e.
- normalise_2: while z_e < -126, shift right 1 and increment z_e, with guard←z_m[0], round_bit←guard, sticky|=round_bit.
- round: if guard && (round_bit | sticky | z_m[0]), increment z_m. If z_m was 0xFFFFFF, also increment z_e.
- pack:
  - exp = z_e + 127, frac = z_m[22:0].
  - z_e == -126 and z_m[23] == 0 → exp field 0 (subnormal).
  - z_e > 127 → inf with sign z_s.
- Latency (rst low, consumers always ready):
  - Normal operands: 2+2 handshake + 2 + 2 (normalise checks) + 103 + 3 + 2 cycles to output_z_stb.
  - Subnormals add up to 23+23+shift cycles.
  - Special cases reach put_z 3 cycles after the b transfer.
- Arithmetic widths: exponent arithmetic is 10-bit two's complement; the largest magnitude reached is ±(127+126+23+26), well within range.

Optional Feature:
- Macro: FLOAT_DIVIDER_FTZ_EN.
- When defined (flush-to-zero):
  - In special_cases, subnormal inputs are treated as signed zero, so x/subnormal gives inf and subnormal/subnormal gives NaN.
  - In pack, any result that would be subnormal is written as signed zero.
  - normalise_a and normalise_b always exit in 1 cycle.
- When undefined: full gradual underflow as described in Behaviour.

Test Plan:
- 6.0/2.0: 0x40C00000 / 0x40000000 → 0x40400000. Sign variant -6.0/2.0 → 0xC0400000.
- 1.0/3.0: 0x3F800000 / 0x40400000 → 0x3EAAAAAB, which exercises the round-up path. 2.0/3.0 → 0x3F2AAAAB.
- Special cases:
  - 1.0/0.0 → 0x7F800000.
  - 0.0/0.0 → 0xFFC00000.
  - inf/inf → 0xFFC00000.
  - -inf/2.0 → 0xFF800000.
  - 1.0/inf → 0x00000000.
  - NaN input → 0xFFC00000.
- Range limits:
  - 0x00800000 / 0x40000000 (2^-126/2) → 0x00400000.
  - Same stimulus with FLOAT_DIVIDER_FTZ_EN → 0x00000000.
  - 0x7F7FFFFF / 0x3F000000 → 0x7F800000 (overflow to inf).
- Handshake:
  - Hold output_z_ack=0 for 10 cycles → output_z_stb and output_z remain stable.
  - Then ack=1 for one cycle → stb drops the next edge and input_a_ack rises within 1 cycle.
  - Delaying input_b_stb by 7 cycles yields the same result.
- Reset mid-operation: assert rst for 1 cycle during divide_2 → next edge shows all acks/stb = 0 and state get_a. A subsequent 6.0/2.0 still returns 0x40400000.
